time_unit_counter: RTL and testbench

//  Generic modulo-N time-unit counter for the watch datapath (seconds, minutes, hours, days).

---
 rtl/time_unit_counter.sv | 160 ++++++++++++++++
 tb/tb_time_unit_counter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/time_unit_counter.sv
// Modulo-N time-unit counter with cascaded carry, set-mode load and
// single-step / hold-to-auto-repeat adjustment.
module time_unit_counter #(
    parameter int MODULUS      = 60,
    parameter int WIDTH        = 6,
    parameter int RESET_VAL    = 0,
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             carry_in,
    input  logic             adj_valid,
    input  logic             adj_up,
    input  logic             adj_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             carry_out,
    output logic             at_max,
    output logic             load_err
);

    localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);

    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);
    localparam logic [TW-1:0]    DELAY_END = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0]    RATE_END  = TW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } rep_state_t;

    rep_state_t       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             load_err_q, load_err_d;

    logic             hold;
    logic             hold_same;
    logic             step;
    logic [WIDTH-1:0] step_val;

    assign hold      = mode & adj_valid & (adj_up ^ adj_dn);
    assign hold_same = hold & (adj_up == dir_q);

    // Direction used by a step: the held button when entering from IDLE, else the latched one.
    always_comb begin
        step_val = count_q;
        if (((state_q == S_IDLE) ? adj_up : dir_q) == 1'b1) begin
            step_val = (count_q == MAX_VAL) ? '0 : count_q + 1'b1;
        end else begin
            step_val = (count_q == '0) ? MAX_VAL : count_q - 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        dir_d      = dir_q;
        count_d    = count_q;
        carry_d    = 1'b0;
        load_err_d = 1'b0;
        step       = 1'b0;

        if (!mode) begin
            state_d = S_IDLE;
            timer_d = '0;
            if (carry_in) begin
                if (count_q == MAX_VAL) begin
                    count_d = '0;
                    carry_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end else if (load) begin
            state_d = S_IDLE;
            timer_d = '0;
            if ({1'b0, load_val} < MOD_EXT) begin
                count_d = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (hold) begin
                        step    = 1'b1;
                        dir_d   = adj_up;
                        timer_d = '0;
                        state_d = S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (!hold_same) begin
                        state_d = S_IDLE;
                        timer_d = '0;
                    end else if (timer_q == DELAY_END) begin
                        step    = 1'b1;
                        timer_d = '0;
                        state_d = S_REPEAT;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (!hold_same) begin
                        state_d = S_IDLE;
                        timer_d = '0;
                    end else if (timer_q == RATE_END) begin
                        step    = 1'b1;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            endcase
            if (step) begin
                count_d = step_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            dir_q      <= 1'b0;
            count_q    <= RST_COUNT;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            dir_q      <= dir_d;
            count_q    <= count_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
        end
    end

    assign count     = count_q;
    assign carry_out = carry_q;
    assign at_max    = (count_q == MAX_VAL);
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_time_unit_counter.sv
// Scoreboard bench for time_unit_counter (MODULUS=60, DELAY=8, RATE=4):
// directed vectors push expected outputs, a monitor pops and compares each cycle.
module tb_time_unit_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mode = 1'b0;
    logic       carry_in = 1'b0;
    logic       adj_valid = 1'b0;
    logic       adj_up = 1'b0;
    logic       adj_dn = 1'b0;
    logic       load = 1'b0;
    logic [5:0] load_val = '0;
    logic [5:0] count;
    logic       carry_out;
    logic       at_max;
    logic       load_err;

    typedef struct {
        string tag;
        int    count;
        int    carry;
        int    at_max;
        int    err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    int dn_exp[20] = '{59, 59, 59, 59, 59, 59, 59, 59, 58, 58,
                       58, 58, 57, 57, 57, 57, 56, 56, 56, 56};
    int up_exp[15] = '{28, 28, 28, 28, 28, 28, 28, 28, 29, 29,
                       29, 29, 30, 30, 30};

    always #5 clk = ~clk;

    time_unit_counter #(
        .MODULUS(60), .WIDTH(6), .RESET_VAL(0), .REPEAT_DELAY(8), .REPEAT_RATE(4)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .carry_in(carry_in),
        .adj_valid(adj_valid), .adj_up(adj_up), .adj_dn(adj_dn),
        .load(load), .load_val(load_val),
        .count(count), .carry_out(carry_out), .at_max(at_max), .load_err(load_err)
    );

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    // One cycle of stimulus, driven on the falling edge; expectation is for the next rising edge.
    task automatic applyStimulus(input string tag, input logic r, input logic m,
                                 input logic ci, input logic av, input logic up,
                                 input logic dn, input logic ld, input int lv,
                                 input int ec, input int ecar, input int eerr);
        exp_t e;
        @(negedge clk);
        rst       = r;
        mode      = m;
        carry_in  = ci;
        adj_valid = av;
        adj_up    = up;
        adj_dn    = dn;
        load      = ld;
        load_val  = 6'(lv);
        e.tag     = tag;
        e.count   = ec;
        e.carry   = ecar;
        e.at_max  = (ec == 59) ? 1 : 0;
        e.err     = eerr;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput({e.tag, ".count"}, int'(count), e.count);
                checkOutput({e.tag, ".carry_out"}, int'(carry_out), e.carry);
                checkOutput({e.tag, ".at_max"}, int'(at_max), e.at_max);
                checkOutput({e.tag, ".load_err"}, int'(load_err), e.err);
            end
        end
    end

    initial begin : stimulus
        //            tag         rst m  ci av up dn ld lv   count carry err
        applyStimulus("reset",     1, 0, 0, 0, 0, 0, 0, 0,    0,   0,   0);

        applyStimulus("ld58",      0, 1, 0, 0, 0, 0, 1, 58,  58,   0,   0);
        applyStimulus("run_ci1",   0, 0, 1, 0, 0, 0, 0, 0,   59,   0,   0);
        applyStimulus("run_wrap",  0, 0, 1, 0, 0, 0, 0, 0,    0,   1,   0);
        applyStimulus("run_idle",  0, 0, 0, 0, 0, 0, 0, 0,    0,   0,   0);
        applyStimulus("run_ignld", 0, 0, 0, 1, 1, 0, 1, 10,   0,   0,   0);

        applyStimulus("ld59",      0, 1, 0, 0, 0, 0, 1, 59,  59,   0,   0);
        applyStimulus("set_ci",    0, 1, 1, 0, 0, 0, 0, 0,   59,   0,   0);
        applyStimulus("set_upwrp", 0, 1, 0, 1, 1, 0, 0, 0,    0,   0,   0);
        applyStimulus("set_rel",   0, 1, 0, 0, 0, 0, 0, 0,    0,   0,   0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus($sformatf("hold_dn%0d", i), 0, 1, 0, 1, 0, 1, 0, 0, dn_exp[i], 0, 0);
        end
        applyStimulus("dn_rel",    0, 1, 0, 0, 0, 0, 0, 0,   56,   0,   0);

        applyStimulus("ld45",      0, 1, 0, 0, 0, 0, 1, 45,  45,   0,   0);
        applyStimulus("ld60_err",  0, 1, 0, 0, 0, 0, 1, 60,  45,   0,   1);
        applyStimulus("err_clr",   0, 1, 0, 0, 0, 0, 0, 0,   45,   0,   0);
        applyStimulus("ld_vs_up",  0, 1, 0, 1, 1, 0, 1, 45,  45,   0,   0);
        applyStimulus("up_after",  0, 1, 0, 1, 1, 0, 0, 0,   46,   0,   0);
        applyStimulus("up_rel",    0, 1, 0, 0, 0, 0, 0, 0,   46,   0,   0);

        applyStimulus("ld27",      0, 1, 0, 0, 0, 0, 1, 27,  27,   0,   0);
        for (int i = 0; i < 15; i++) begin
            applyStimulus($sformatf("hold_up%0d", i), 0, 1, 0, 1, 1, 0, 0, 0, up_exp[i], 0, 0);
        end
        applyStimulus("rst_rep",   1, 1, 0, 1, 1, 0, 0, 0,    0,   0,   0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("post_rst%0d", i), 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end

        applyStimulus("ld59b",     0, 1, 0, 0, 0, 0, 1, 59,  59,   0,   0);
        applyStimulus("rst_wrap",  1, 0, 1, 0, 0, 0, 0, 0,    0,   0,   0);
        applyStimulus("post_wrap", 0, 0, 0, 0, 0, 0, 0, 0,    0,   0,   0);

        @(negedge clk);
        rst = 1'b0; mode = 1'b0; carry_in = 1'b0; adj_valid = 1'b0;
        adj_up = 1'b0; adj_dn = 1'b0; load = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
